// File: rtl/pc_pkg.sv
// pc_pkg: shared FSM/pending enums and alignment helpers for pc_gen
package pc_pkg;
  typedef enum logic {BOOT, RUN} state_e;
  typedef enum logic [1:0] {NONE, BR, TRAP} pend_e;
  localparam int INST_BYTES_DEF = 4;
  localparam int ALIGN_BITS = $clog2(INST_BYTES_DEF);
  function automatic int align_bits(input int inst_bytes);
    return $clog2(inst_bytes);
  endfunction
endpackage

// File: rtl/pc_redirect_hold.sv
// pc_redirect_hold: pending redirect register where a trap is never replaced by a later branch
module pc_redirect_hold import pc_pkg::*; #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              capture,
  input  logic              consume,
  input  logic              is_trap,
  input  logic [ADDR_W-1:0] tgt,
  output logic              pend_vld,
  output logic [ADDR_W-1:0] pend_tgt
);
  pend_e src_q, src_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  always_comb begin
    src_d = consume ? NONE : src_q;
    tgt_d = tgt_q;
    if (capture && (is_trap || src_q != TRAP)) begin
      src_d = is_trap ? TRAP : BR;
      tgt_d = tgt;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      src_q <= NONE;
      tgt_q <= '0;
    end else begin
      src_q <= src_d;
      tgt_q <= tgt_d;
    end
  end
  assign pend_vld = src_q != NONE;
  assign pend_tgt = tgt_q;
endmodule

// File: rtl/pc_gen.sv
// pc_gen: RISC-V fetch PC generator; PC_ALIGN_CHK_EN drops misaligned redirect targets instead of masking them
module pc_gen import pc_pkg::*; #(
  parameter int                ADDR_W     = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC  = '0,
  parameter int                INST_BYTES = 1 << ALIGN_BITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stallreq,
  input  logic              br,
  input  logic [ADDR_W-1:0] bt,
  input  logic              trap,
  input  logic [ADDR_W-1:0] tvec,
  input  logic              fetch_ready,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              misalign
);
  localparam int AB = align_bits(INST_BYTES);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d, pend_tgt, tvec_a, bt_a, pend_a;
  logic ce_q, ce_d, mis_q, mis_d, adv, pend_vld, trap_ok, br_ok, pend_ok;
  assign adv = state_q == RUN && !stallreq && fetch_ready;
  pc_redirect_hold #(.ADDR_W(ADDR_W)) u_hold (
    .clk      (clk),
    .rst      (rst),
    .capture  (!adv && (trap || br)),
    .consume  (adv),
    .is_trap  (trap),
    .tgt      (trap ? tvec : bt),
    .pend_vld (pend_vld),
    .pend_tgt (pend_tgt)
  );
`ifdef PC_ALIGN_CHK_EN
  assign tvec_a  = tvec;
  assign bt_a    = bt;
  assign pend_a  = pend_tgt;
  assign trap_ok = trap && tvec[AB-1:0] == '0;
  assign br_ok   = br && bt[AB-1:0] == '0;
  assign pend_ok = pend_vld && pend_tgt[AB-1:0] == '0;
  assign mis_d   = adv && ((trap && !trap_ok) || (!trap_ok && br && !br_ok) ||
                           (!trap_ok && !br_ok && pend_vld && !pend_ok));
`else
  localparam logic [ADDR_W-1:0] MASK = {{(ADDR_W-AB){1'b1}}, {AB{1'b0}}};
  assign tvec_a  = tvec & MASK;
  assign bt_a    = bt & MASK;
  assign pend_a  = pend_tgt & MASK;
  assign trap_ok = trap;
  assign br_ok   = br;
  assign pend_ok = pend_vld;
  assign mis_d   = 1'b0;
`endif
  always_comb begin
    state_d = state_q == BOOT ? RUN : state_q;
    ce_d = 1'b1;
    pc_d = !adv ? pc_q : trap_ok ? tvec_a : br_ok ? bt_a : pend_ok ? pend_a : pc_q + ADDR_W'(INST_BYTES);
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= BOOT;
      pc_q <= RESET_VEC;
      ce_q <= 1'b0;
      mis_q <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      ce_q <= ce_d;
      mis_q <= mis_d;
    end
  end
  assign pc = pc_q;
  assign ce = ce_q;
  assign misalign = mis_q;
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed plus random stimulus for pc_gen against a behavioural fetch-address model
module tb_pc_gen;
  logic clk = 1'b0, rst, stallreq, br, trap, fetch_ready, ce, misalign;
  logic [31:0] bt, tvec, pc;
  int n_cmp = 0, n_bad = 0;
  logic chk_on = 1'b0;
  logic [31:0] m_pc, p_tgt;
  logic m_ce, m_mis, m_run, p_vld, p_trap;

  pc_gen dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .br(br), .bt(bt), .trap(trap),
    .tvec(tvec), .fetch_ready(fetch_ready), .pc(pc), .ce(ce), .misalign(misalign)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, req, $time);
    end
  endtask

  task automatic m_reset();
    m_pc = 32'h0; m_ce = 0; m_mis = 0; m_run = 0; p_vld = 0; p_trap = 0; p_tgt = 0;
  endtask

  task automatic m_capture();
    if (trap) begin
      p_vld = 1; p_trap = 1; p_tgt = tvec;
    end else if (br && !(p_vld && p_trap)) begin
      p_vld = 1; p_trap = 0; p_tgt = bt;
    end
  endtask

  task automatic m_try(input logic en, input logic [31:0] t, inout logic done);
    if (en && !done) begin
`ifdef PC_ALIGN_CHK_EN
      if (t % 4 == 0) begin
        m_pc = t; done = 1;
      end else m_mis = 1;
`else
      m_pc = t - t % 4; done = 1;
`endif
    end
  endtask

  task automatic m_step();
    logic done;
    done = 0;
    m_mis = 0;
    if (rst) m_reset();
    else if (!m_run) begin
      m_run = 1; m_ce = 1; m_capture();
    end else if (!stallreq && fetch_ready) begin
      m_try(trap, tvec, done);
      m_try(br, bt, done);
      m_try(p_vld, p_tgt, done);
      if (!done) m_pc = m_pc + 32'd4;
      p_vld = 0;
    end else m_capture();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    m_step();
  endtask

  task automatic go(input logic s, input logic f, input logic b, input logic [31:0] btv,
                    input logic t, input logic [31:0] tv);
    stallreq = s; fetch_ready = f; br = b; bt = btv; trap = t; tvec = tv;
    tick();
  endtask

  function automatic logic [31:0] rnd_tgt();
    logic [31:0] t;
    t = $urandom & 32'hFFFF_FFFC;
    if ($urandom_range(0, 9) == 0) t = $urandom;
    if ($urandom_range(0, 19) == 0) t = 32'hFFFF_FFF0 | (t & 32'hF);
    return t;
  endfunction

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      chk("pc", pc, m_pc);
      chk("ce", 32'(ce), 32'(m_ce));
      chk("misalign", 32'(misalign), 32'(m_mis));
    end
  end

  initial begin
    rst = 1; stallreq = 0; fetch_ready = 1; br = 0; trap = 0; bt = 0; tvec = 0;
    m_reset();
    chk_on = 1;
    tick(); tick();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ce", 32'(ce), 32'h0);
    rst = 0;
    go(0, 1, 0, 0, 0, 0);
    chk("boot_ce", 32'(ce), 32'h1);
    chk("boot_pc", pc, 32'h0);
    go(0, 1, 0, 0, 0, 0);
    chk("seq_4", pc, 32'h4);
    go(0, 1, 0, 0, 0, 0);
    chk("seq_8_model", m_pc, 32'h8);
    go(1, 1, 1, 32'h100, 0, 0);
    go(1, 1, 0, 0, 0, 0);
    go(1, 1, 0, 0, 0, 0);
    chk("stall_hold", pc, 32'h8);
    go(0, 1, 0, 0, 0, 0);
    chk("pend_br", pc, 32'h100);
    go(0, 1, 0, 0, 0, 0);
    chk("pend_br_next", pc, 32'h104);
    go(1, 1, 1, 32'h200, 0, 0);
    go(1, 1, 0, 0, 1, 32'h80);
    go(1, 1, 0, 0, 0, 0);
    go(0, 1, 0, 0, 0, 0);
    chk("br_then_trap", pc, 32'h80);
    chk("br_then_trap_model", m_pc, 32'h80);
    go(1, 1, 0, 0, 1, 32'hC0);
    go(1, 1, 1, 32'h200, 0, 0);
    go(0, 1, 0, 0, 0, 0);
    chk("trap_then_br", pc, 32'hC0);
    go(0, 1, 1, 32'h10, 0, 0);
    chk("direct_br", pc, 32'h10);
    go(0, 0, 0, 0, 0, 0);
    go(0, 0, 0, 0, 0, 0);
    chk("not_ready_hold", pc, 32'h10);
    chk("not_ready_ce", 32'(ce), 32'h1);
    go(0, 1, 0, 0, 0, 0);
    chk("ready_adv", pc, 32'h14);
    go(0, 1, 1, 32'hFFFF_FFFC, 0, 0);
    chk("pre_wrap", pc, 32'hFFFF_FFFC);
    go(0, 1, 0, 0, 0, 0);
    chk("wrap", pc, 32'h0);
    go(0, 1, 1, 32'h102, 0, 0);
`ifdef PC_ALIGN_CHK_EN
    chk("misalign_pc", pc, 32'h4);
    chk("misalign_pulse", 32'(misalign), 32'h1);
`else
    chk("mask_pc", pc, 32'h100);
    chk("mask_no_pulse", 32'(misalign), 32'h0);
`endif
    go(0, 1, 0, 0, 0, 0);
    chk("misalign_clear", 32'(misalign), 32'h0);
    go(1, 1, 1, 32'h300, 0, 0);
    br = 0;
    #1;
    rst = 1;
    m_reset();
    #1;
    chk("async_pc", pc, 32'h0);
    chk("async_ce", 32'(ce), 32'h0);
    tick();
    rst = 0;
    go(0, 1, 0, 0, 0, 0);
    chk("reboot_ce", 32'(ce), 32'h1);
    go(0, 1, 0, 0, 0, 0);
    chk("pend_cleared", pc, 32'h4);
    for (int i = 0; i < 3000; i++) begin
      rst = $urandom_range(0, 299) == 0;
      if (rst) m_reset();
      stallreq = $urandom_range(0, 3) == 0;
      fetch_ready = $urandom_range(0, 3) != 0;
      br = $urandom_range(0, 4) == 0;
      bt = rnd_tgt();
      trap = $urandom_range(0, 11) == 0;
      tvec = rnd_tgt();
      tick();
    end
    rst = 0;
    @(negedge clk);
    chk_on = 0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
